// File: rtl/cdc_sync_filt.sv
// Multi-channel N-stage level synchronizer with optional stability filter and rise/fall pulses.
// Latency: STAGES edges (FILT=0) or STAGES+FILT edges; CE=0 freezes all state and clears pulses.
// No backpressure: free-running level path, every channel independent.
module cdc_sync_filt #(
    parameter int             W       = 8,
    parameter int             STAGES  = 2,
    parameter int             FILT    = 0,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CE,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q,
    output logic [W-1:0] RISE,
    output logic [W-1:0] FALL
);

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("cdc_sync_filt: STAGES must be 2..4");
    end
    if (FILT < 0 || FILT > 255) begin : g_bad_filt
        $error("cdc_sync_filt: FILT must be 0..255");
    end

    // Only s[0] sees the asynchronous input; stages are plain flop-to-flop.
    logic [W-1:0] s [STAGES];
    logic [W-1:0] syn;

    assign syn = s[STAGES-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < STAGES; k++) s[k] <= RST_VAL;
        end else if (CE) begin
            s[0] <= D;
            for (int k = 1; k < STAGES; k++) s[k] <= s[k-1];
        end
    end

    if (FILT == 0) begin : g_bypass
        logic [W-1:0] rise_r, fall_r;

        // Look one stage ahead so the pulse lands in the same cycle syn changes.
        always_ff @(posedge CLK) begin
            if (RST || !CE) begin
                rise_r <= '0;
                fall_r <= '0;
            end else begin
                rise_r <= s[STAGES-2] & ~syn;
                fall_r <= ~s[STAGES-2] & syn;
            end
        end

        assign Q    = syn;
        assign RISE = rise_r;
        assign FALL = fall_r;
    end else begin : g_filt
        localparam int            CW   = $clog2(FILT + 1);
        localparam logic [CW-1:0] LAST = CW'(FILT - 1);

        logic [CW-1:0] cnt [W];
        logic [W-1:0]  q_r, rise_r, fall_r, diff, upd;

        assign diff = syn ^ q_r;

        always_comb begin
            upd = '0;
            for (int i = 0; i < W; i++) upd[i] = diff[i] && (cnt[i] == LAST);
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                q_r    <= RST_VAL;
                rise_r <= '0;
                fall_r <= '0;
                for (int i = 0; i < W; i++) cnt[i] <= '0;
            end else if (CE) begin
                for (int i = 0; i < W; i++) begin
                    if (!diff[i] || upd[i]) cnt[i] <= '0;
                    else                    cnt[i] <= cnt[i] + 1'b1;
                end
                q_r    <= q_r ^ upd;
                rise_r <= upd & syn;
                fall_r <= upd & ~syn;
            end else begin
                rise_r <= '0;
                fall_r <= '0;
            end
        end

        assign Q    = q_r;
        assign RISE = rise_r;
        assign FALL = fall_r;
    end

endmodule

// File: tb/tb_cdc_sync_filt.sv
// Bench for cdc_sync_filt: four parameterisations driven in parallel, checked against a
// sample-history reference model every cycle, plus directed latency/filter/CE/reset cases.
module tb_cdc_sync_filt;

    localparam int NI = 4;
    localparam int ST0 = 2, FL0 = 0;
    localparam int ST1 = 3, FL1 = 4;
    localparam int ST2 = 2, FL2 = 4;
    localparam int ST3 = 4, FL3 = 1;
    localparam logic [7:0] RV0 = 8'h00, RV1 = 8'h00, RV2 = 8'hFF, RV3 = 8'h5A;
    localparam int HMAX = 8192;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CE  = 1'b1;
    logic [7:0] D   = 8'h00;
    logic [7:0] q [NI];
    logic [7:0] rise [NI];
    logic [7:0] fall [NI];

    int         st [NI];
    int         fl [NI];
    logic [7:0] rv [NI];

    logic [7:0] dh [NI][HMAX];
    int         nd [NI];
    int         run [NI][8];
    logic [7:0] mq [NI];
    logic [7:0] mr [NI];
    logic [7:0] mf [NI];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    cdc_sync_filt #(.W(8), .STAGES(ST0), .FILT(FL0), .RST_VAL(RV0)) u0 (
        .CLK(CLK), .RST(RST), .CE(CE), .D(D), .Q(q[0]), .RISE(rise[0]), .FALL(fall[0]));
    cdc_sync_filt #(.W(8), .STAGES(ST1), .FILT(FL1), .RST_VAL(RV1)) u1 (
        .CLK(CLK), .RST(RST), .CE(CE), .D(D), .Q(q[1]), .RISE(rise[1]), .FALL(fall[1]));
    cdc_sync_filt #(.W(8), .STAGES(ST2), .FILT(FL2), .RST_VAL(RV2)) u2 (
        .CLK(CLK), .RST(RST), .CE(CE), .D(D), .Q(q[2]), .RISE(rise[2]), .FALL(fall[2]));
    cdc_sync_filt #(.W(8), .STAGES(ST3), .FILT(FL3), .RST_VAL(RV3)) u3 (
        .CLK(CLK), .RST(RST), .CE(CE), .D(D), .Q(q[3]), .RISE(rise[3]), .FALL(fall[3]));

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Synchronized level = the input sampled STAGES enabled edges ago, else the reset value.
    function automatic logic [7:0] msyn(input int i);
        if (nd[i] >= st[i]) return dh[i][nd[i] - st[i]];
        return rv[i];
    endfunction

    task automatic model_step(input int i);
        logic [7:0] sp, old;
        if (RST) begin
            nd[i] = 0;
            mq[i] = rv[i];
            mr[i] = 8'h00;
            mf[i] = 8'h00;
            for (int b = 0; b < 8; b++) run[i][b] = 0;
        end else if (!CE) begin
            mr[i] = 8'h00;
            mf[i] = 8'h00;
        end else begin
            sp  = msyn(i);
            old = mq[i];
            if (nd[i] < HMAX) begin
                dh[i][nd[i]] = D;
                nd[i]++;
            end
            if (fl[i] == 0) begin
                mq[i] = msyn(i);
            end else begin
                for (int b = 0; b < 8; b++) begin
                    if (sp[b] != mq[i][b]) begin
                        run[i][b]++;
                        if (run[i][b] == fl[i]) begin
                            mq[i][b]  = sp[b];
                            run[i][b] = 0;
                        end
                    end else begin
                        run[i][b] = 0;
                    end
                end
            end
            mr[i] = mq[i] & ~old;
            mf[i] = ~mq[i] & old;
        end
    endtask

    task automatic tick(input logic r, input logic c, input logic [7:0] d);
        @(negedge CLK);
        RST = r;
        CE  = c;
        D   = d;
        @(posedge CLK);
        for (int i = 0; i < NI; i++) model_step(i);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("q%0d", i),    q[i],    mq[i]);
            chk($sformatf("rise%0d", i), rise[i], mr[i]);
            chk($sformatf("fall%0d", i), fall[i], mf[i]);
            chk($sformatf("rf_excl%0d", i), rise[i] & fall[i], 8'h00);
        end
    endtask

    initial begin
        logic [7:0] dv;
        st = '{ST0, ST1, ST2, ST3};
        fl = '{FL0, FL1, FL2, FL3};
        rv = '{RV0, RV1, RV2, RV3};

        // Reset state
        tick(1'b1, 1'b1, 8'h00);
        tick(1'b1, 1'b1, 8'hA5);
        chk("rst_q2", q[2], 8'hFF);
        chk("rst_q3", q[3], 8'h5A);
        chk("rst_rise3", rise[3], 8'h00);

        // Two-stage bypass latency
        tick(1'b0, 1'b1, 8'h81);
        chk("t1_e1_q0", q[0], 8'h00);
        tick(1'b0, 1'b1, 8'h81);
        chk("t1_e2_q0", q[0], 8'h81);
        chk("t1_e2_rise0", rise[0], 8'h81);
        chk("t1_e2_fall0", fall[0], 8'h00);
        tick(1'b0, 1'b1, 8'h81);
        chk("t1_e3_rise0", rise[0], 8'h00);

        // STAGES=3, FILT=4: held level appears after 7 edges
        tick(1'b1, 1'b1, 8'h00);
        for (int e = 1; e <= 8; e++) begin
            tick(1'b0, 1'b1, 8'h01);
            if (e == 6) chk("t2_e6_q1", q[1], 8'h00);
            if (e == 7) begin
                chk("t2_e7_q1", q[1], 8'h01);
                chk("t2_e7_rise1", rise[1], 8'h01);
            end
            if (e == 8) chk("t2_e8_rise1", rise[1], 8'h00);
        end

        // Short glitch never reaches the filtered output
        tick(1'b1, 1'b1, 8'h00);
        for (int e = 0; e < 3; e++) tick(1'b0, 1'b1, 8'h01);
        for (int e = 0; e < 10; e++) tick(1'b0, 1'b1, 8'h00);
        chk("t2_glitch_q1", q[1], 8'h00);

        // Mismatch run broken by one matching sample restarts the count
        tick(1'b1, 1'b1, 8'h00);
        dv = 8'h01;
        for (int e = 0; e < 14; e++) tick(1'b0, 1'b1, (e == 3) ? 8'h00 : dv);

        // Clock enable low in the middle of a count
        tick(1'b1, 1'b1, 8'h00);
        for (int e = 0; e < 5; e++) tick(1'b0, 1'b1, 8'h01);
        for (int e = 0; e < 3; e++) begin
            tick(1'b0, 1'b0, 8'h01);
            chk("t4_hold_q1", q[1], 8'h00);
        end
        tick(1'b0, 1'b1, 8'h01);
        chk("t4_r1_q1", q[1], 8'h00);
        tick(1'b0, 1'b1, 8'h01);
        chk("t4_r2_q1", q[1], 8'h01);
        chk("t4_r2_rise1", rise[1], 8'h01);

        // Reset mid-count with a non-zero reset value
        tick(1'b1, 1'b1, 8'h0F);
        for (int e = 0; e < 3; e++) tick(1'b0, 1'b1, 8'h0F);
        tick(1'b1, 1'b1, 8'h0F);
        chk("t5_rst_q2", q[2], 8'hFF);
        for (int e = 1; e <= 6; e++) begin
            tick(1'b0, 1'b1, 8'h0F);
            if (e == 1) chk("t5_rel_fall2", fall[2], 8'h00);
            if (e == 5) chk("t5_e5_q2", q[2], 8'hFF);
            if (e == 6) begin
                chk("t5_e6_fall2", fall[2], 8'hF0);
                chk("t5_e6_q2", q[2], 8'h0F);
            end
        end

        // Randomized sparse toggling, occasional CE gaps and resets
        dv = 8'h00;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 2) == 0)
                dv = dv ^ 8'($urandom & $urandom & $urandom);
            tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), dv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
